// File: rtl/bool_lut_pkg.sv
// Shared constants and width helpers for the programmable Boolean LUT pipeline.
// Index convention for the default table is {c,b,a}.
package bool_lut_pkg;

  // (~a & ~b) | ~c
  localparam logic [7:0] BOOL_TT_DEFAULT = 8'h1F;

  function automatic int TT_W(input int n_in);
    return 32'sd1 <<< n_in;
  endfunction

  function automatic int CH_IDX_W(input int ch);
    return (ch > 32'sd1) ? $clog2(ch) : 32'sd1;
  endfunction

endpackage

// File: rtl/bool_lut_ch.sv
// One channel: shadow/active truth tables, lookup mux and saturating ones counter.
// The active table only changes on commit, so lookups are never disturbed by plain writes.
module bool_lut_ch
  import bool_lut_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int CNT_W = 16,
  parameter logic [TT_W(N_IN)-1:0] INIT_TT = BOOL_TT_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_we_i,
  input  logic [TT_W(N_IN)-1:0] cfg_tt_i,
  input  logic                  cfg_commit_i,
  input  logic [N_IN-1:0]       idx_i,
  output logic                  result_o,
  input  logic                  out_bit_i,
  input  logic                  out_xfer_i,
  input  logic                  cnt_clr_i,
  output logic [CNT_W-1:0]      ones_cnt_o
);

  localparam int TTW = TT_W(N_IN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [TTW-1:0]   shadow_q, shadow_d;
  logic [TTW-1:0]   active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Table next state: commit copies the already-updated shadow (write-through).
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (cfg_we_i) begin
      shadow_d = cfg_tt_i;
    end else begin
      shadow_d = shadow_q;
    end
    if (cfg_commit_i) begin
      active_d = shadow_d;
    end else begin
      active_d = active_q;
    end
  end

  // Counter next state: clear dominates, increment saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (out_xfer_i && out_bit_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= INIT_TT;
      active_q <= INIT_TT;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result_o   = active_q[idx_i];
  assign ones_cnt_o = cnt_q;

endmodule

// File: rtl/bool_lut_pipe_chk.sv
// Output-side flow properties of the LUT pipeline.
module bool_lut_pipe_chk #(
  parameter int CH = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          out_valid,
  input logic          out_ready,
  input logic [CH-1:0] out_data
);

  // A stalled result must stay valid and unchanged until the consumer takes it.
  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: rtl/bool_lut_pipe.sv
// Multi-channel programmable Boolean evaluator with a two-stage valid/ready pipeline.
// Stage A holds raw inputs; the lookup happens on the A->B move, stage B feeds the output.
module bool_lut_pipe
  import bool_lut_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int CH    = 4,
  parameter int CNT_W = 16,
  parameter logic [TT_W(N_IN)-1:0] INIT_TT = BOOL_TT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH*N_IN-1:0]      in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH-1:0]           out_data,
  input  logic                    cfg_we,
  input  logic [CH_IDX_W(CH)-1:0] cfg_ch,
  input  logic [TT_W(N_IN)-1:0]   cfg_tt,
  input  logic                    cfg_commit,
  input  logic                    cnt_clr,
  output logic [CH*CNT_W-1:0]     ones_cnt
);

  localparam int CW = CH_IDX_W(CH);

  logic                 a_valid_q, a_valid_d;
  logic [CH*N_IN-1:0]   a_data_q, a_data_d;
  logic                 b_valid_q, b_valid_d;
  logic [CH-1:0]        b_data_q, b_data_d;
  logic                 a_ready_s, b_ready_s;
  logic                 ab_xfer_s, out_xfer_s;
  logic [CH-1:0]        cfg_hit_s;
  logic [CH-1:0]        lookup_s;

  // Ready chain; out_ready -> in_ready is the only combinational path through the block.
  always_comb begin
    b_ready_s  = ~b_valid_q | out_ready;
    a_ready_s  = ~a_valid_q | b_ready_s;
    ab_xfer_s  = a_valid_q & b_ready_s;
    out_xfer_s = b_valid_q & out_ready;
  end

  // Channel select for config writes; out-of-range indices match nothing.
  always_comb begin
    cfg_hit_s = {CH{1'b0}};
    for (int k = 0; k < CH; k++) begin
      cfg_hit_s[k] = cfg_we && (cfg_ch == CW'(k));
    end
  end

  // Pipeline next state.
  always_comb begin
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    if (a_ready_s) begin
      a_valid_d = in_valid;
    end else begin
      a_valid_d = a_valid_q;
    end
    if (a_ready_s && in_valid) begin
      a_data_d = in_data;
    end else begin
      a_data_d = a_data_q;
    end
    if (b_ready_s) begin
      b_valid_d = a_valid_q;
    end else begin
      b_valid_d = b_valid_q;
    end
    if (ab_xfer_s) begin
      b_data_d = lookup_s;
    end else begin
      b_data_d = b_data_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_data_q  <= {(CH*N_IN){1'b0}};
      b_valid_q <= 1'b0;
      b_data_q  <= {CH{1'b0}};
    end else begin
      a_valid_q <= a_valid_d;
      a_data_q  <= a_data_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    bool_lut_ch #(
      .N_IN    (N_IN),
      .CNT_W   (CNT_W),
      .INIT_TT (INIT_TT)
    ) u_ch (
      .clk_i        (clk),
      .rst_i        (rst),
      .cfg_we_i     (cfg_hit_s[k]),
      .cfg_tt_i     (cfg_tt),
      .cfg_commit_i (cfg_commit),
      .idx_i        (a_data_q[k*N_IN +: N_IN]),
      .result_o     (lookup_s[k]),
      .out_bit_i    (b_data_q[k]),
      .out_xfer_i   (out_xfer_s),
      .cnt_clr_i    (cnt_clr),
      .ones_cnt_o   (ones_cnt[k*CNT_W +: CNT_W])
    );
  end

  bool_lut_pipe_chk #(.CH(CH)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .out_valid (b_valid_q),
    .out_ready (out_ready),
    .out_data  (b_data_q)
  );

  assign in_ready  = a_ready_s;
  assign out_valid = b_valid_q;
  assign out_data  = b_data_q;

endmodule

// File: tb/tb_bool_lut_pipe.sv
// Scoreboard bench for bool_lut_pipe: expected results are queued at acceptance
// from a table model and checked by a monitor on every output transfer.
module tb_bool_lut_pipe;

  localparam int N_IN  = 3;
  localparam int CH    = 4;
  localparam int CNT_W = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [7:0]  cfg_tt;
  logic        cfg_commit;
  logic        cnt_clr;
  logic [15:0] ones_cnt;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [7:0] m_act[4];
  logic [7:0] m_shd[4];
  int         cnt_m[4];
  logic [3:0] mon_e;

  bool_lut_pipe #(.N_IN(N_IN), .CH(CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_tt(cfg_tt), .cfg_commit(cfg_commit),
    .cnt_clr(cnt_clr), .ones_cnt(ones_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] model_out(input logic [11:0] d);
    logic [3:0] r;
    logic [7:0] t;
    logic [2:0] ix;
    for (int k = 0; k < 4; k++) begin
      t    = m_act[k];
      ix   = d[k*3 +: 3];
      r[k] = t[ix];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_act[k] = 8'h1F;
      m_shd[k] = 8'h1F;
      cnt_m[k] = 0;
    end
    exp_q.delete();
  endtask

  // Monitor: checks counters every cycle and scoreboard on every output transfer.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) cnt_m[k] = 0;
      exp_q.delete();
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ones_cnt[k*4 +: 4] !== 4'(cnt_m[k])) begin
          errors++;
          $display("FAIL ones_cnt[%0d] got %0d expected %0d at %0t", k, ones_cnt[k*4 +: 4], cnt_m[k], $time);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got %h expected none at %0t", out_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_data !== mon_e) begin
            errors++;
            $display("FAIL out_data got %h expected %h at %0t", out_data, mon_e, $time);
          end
          for (int k = 0; k < 4; k++) begin
            if (mon_e[k] && cnt_m[k] < 15) cnt_m[k]++;
          end
        end
      end
      if (cnt_clr) begin
        for (int k = 0; k < 4; k++) cnt_m[k] = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [11:0] d);
    int waitc;
    waitc    = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && waitc < 20) begin
      @(posedge clk);
      #1;
      waitc++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout got in_ready=%b expected 1 at %0t", in_ready, $time);
    end else begin
      exp_q.push_back(model_out(d));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 12'h000; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_ch = 2'd0; cfg_tt = 8'h00; cfg_commit = 1'b0; cnt_clr = 1'b0;
    model_reset();
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || ones_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h c=%h expected 0/0/0", out_valid, out_data, ones_cnt);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b expected 1", in_ready);
    end
    step();
  endtask

  task automatic test_defaults();
    out_ready = 1'b1;
    send_beat(12'h004);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early got %b expected 0", out_valid);
    end
    send_beat(12'h005);
    checks++;
    if (out_valid !== 1'b1 || out_data[0] !== 1'b1) begin
      errors++;
      $display("FAIL default_100 got v=%b d0=%b expected 1/1", out_valid, out_data[0]);
    end
    send_beat(12'h000);
    checks++;
    if (out_data[0] !== 1'b0) begin
      errors++;
      $display("FAIL default_101 got %b expected 0", out_data[0]);
    end
    send_beat(12'h007);
    checks++;
    if (out_data[0] !== 1'b1) begin
      errors++;
      $display("FAIL default_000 got %b expected 1", out_data[0]);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data[0] !== 1'b0) begin
      errors++;
      $display("FAIL default_111 got v=%b d0=%b expected 1/0", out_valid, out_data[0]);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [11:0] beats[6];
    logic [3:0]  hold_d;
    int          accepted;
    for (int i = 0; i < 6; i++) beats[i] = 12'($urandom);
    accepted  = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_data = beats[accepted];
      #1;
      if (in_ready) begin
        exp_q.push_back(model_out(beats[accepted]));
        accepted++;
      end
      step();
    end
    checks++;
    if (accepted !== 2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept got %0d/%b expected 2/0", accepted, in_ready);
    end
    hold_d = out_data;
    step();
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== hold_d) begin
      errors++;
      $display("FAIL bp_stable got v=%b d=%h expected 1/%h", out_valid, out_data, hold_d);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (accepted < 6);
      if (accepted < 6) in_data = beats[accepted];
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_gap got out_valid=%b expected 1 cycle %0d", out_valid, c);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_out(beats[accepted]));
        accepted++;
      end
      step();
    end
    checks++;
    if (accepted !== 6) begin
      errors++;
      $display("FAIL bp_total got %0d expected 6", accepted);
    end
    drain();
  endtask

  task automatic test_reconfig();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_tt = 8'h80;
    step();
    cfg_we = 1'b0;
    m_shd[1] = 8'h80;
    send_beat(12'h038);
    send_beat(12'($urandom));
    drain();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    for (int k = 0; k < 4; k++) m_act[k] = m_shd[k];
    send_beat(12'h038);
    send_beat(12'h000);
    for (int i = 0; i < 4; i++) send_beat(12'($urandom));
    drain();
  endtask

  task automatic test_commit_timing();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_tt = 8'h00;
    step();
    cfg_we = 1'b0;
    m_shd[0] = 8'h00;
    out_ready = 1'b1;
    send_beat(12'h000);
    in_valid   = 1'b0;
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    for (int k = 0; k < 4; k++) m_act[k] = m_shd[k];
    send_beat(12'h000);
    drain();
  endtask

  task automatic test_commit_write();
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_tt = 8'hFF; cfg_commit = 1'b1;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    m_shd[2] = 8'hFF;
    for (int k = 0; k < 4; k++) m_act[k] = m_shd[k];
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(12'($urandom));
    drain();
  endtask

  task automatic test_counter();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send_beat({3'b000, 9'($urandom)});
    drain();
    step();
    checks++;
    if (ones_cnt[15:12] !== 4'd15) begin
      errors++;
      $display("FAIL cnt_saturate got %0d expected 15", ones_cnt[15:12]);
    end
    send_beat({3'b000, 9'h000});
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL cnt_clr_setup got out_valid=%b expected 1", out_valid);
    end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++;
    if (ones_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL cnt_clr_wins got %h expected 0000", ones_cnt);
    end
    drain();
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) begin
      cfg_we = 1'b1; cfg_ch = 2'(k); cfg_tt = 8'h00; cfg_commit = (k == 3);
      step();
    end
    cfg_we = 1'b0; cfg_commit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_shd[k] = 8'h00;
      m_act[k] = 8'h00;
    end
    out_ready = 1'b0;
    send_beat(12'($urandom));
    send_beat(12'($urandom));
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_setup got v=%b r=%b expected 1/0", out_valid, in_ready);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ones_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL rst_async got v=%b c=%h expected 0/0000", out_valid, ones_cnt);
    end
    model_reset();
    #1;
    rst = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_after got v=%b r=%b expected 0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    send_beat(12'h000);
    send_beat(12'hFFF);
    send_beat(12'h924);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_defaults();
    test_backpressure();
    test_reconfig();
    test_commit_timing();
    test_commit_write();
    test_counter();
    test_async_reset();
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
